// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shift unit for the ALU datapath. The unit moves the operand by
// one bit position per clock, so a large shift amount costs cycles instead of
// a wide barrel shifter. The ALU controller pulses start and then waits for
// done.
//
// Modes (captured with start):
//   2'b00 SLL  logical left
//   2'b01 SRL  logical right
//   2'b10 SRA  arithmetic right (sign bit replicated)
//   2'b11 ROL  rotate left
//
// Parameters:
//   WIDTH    data width in bits, >= 2
//   SHAMT_W  shift-amount width, equal to $clog2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; overrides every other input
//   start      request, sampled only while idle
//   a          operand, captured on accept
//   amt        shift amount 0..WIDTH-1, captured on accept
//   mode       shift mode, captured on accept
//   y          result; meaningful while done=1, held until the next accept
//   carry_out  last bit shifted or rotated out; 0 when amt=0
//   busy       high whenever the unit is not idle (SHIFT and DONE)
//   done       single-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   y,
    output logic               carry_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [SHAMT_W-1:0] count_r;
    logic [1:0]         mode_r;
    logic [WIDTH-1:0]   y_r;
    logic               carry_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH:0]     step_s;

    // One-position shift step. The MSB of the return value is the bit that
    // leaves the word; the remaining WIDTH bits are the shifted word.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] val,
        input logic [1:0]       md
    );
        logic [WIDTH:0] res;
        case (md)
            MODE_SLL: res = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            MODE_SRL: res = {val[0], 1'b0, val[WIDTH-1:1]};
            MODE_SRA: res = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            MODE_ROL: res = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
            default:  res = {1'b0, val};
        endcase
        return res;
    endfunction

    // Next shifted value of the working register under the latched mode.
    always_comb begin
        step_s = shift_step(y_r, mode_r);
    end

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            mode_r  <= MODE_SLL;
            y_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        y_r     <= a;
                        count_r <= amt;
                        mode_r  <= mode;
                        carry_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (amt == CNT_ZERO) begin
                            // Nothing to shift: report completion right away.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    y_r     <= step_s[WIDTH-1:0];
                    carry_r <= step_s[WIDTH];
                    count_r <= count_r - CNT_ONE;
                    // The step that drains the counter is the final one.
                    if (count_r == CNT_ONE) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here; it does not queue.
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign y         = y_r;
    assign carry_out = carry_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
